// File: rtl/feistel_round_ctrl.sv
// Feistel round sequencer: loads a block, runs ROUNDS rounds through an external F, holds the unswapped result.
// Ports: CLK/RESET, IN_* upstream handshake, KEY_INDEX/F_R/F_OUT to key schedule and F, LEFT16/RIGHT16/OUT_* downstream, BUSY.
module feistel_round_ctrl #(
  parameter int ROUNDS = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        DECRYPT,
  input  logic [32:1] LEFT0,
  input  logic [32:1] RIGHT0,
  output logic [3:0]  KEY_INDEX,
  output logic [32:1] F_R,
  input  logic [32:1] F_OUT,
  output logic [32:1] LEFT16,
  output logic [32:1] RIGHT16,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [32:1] l_q, l_d;
  logic [32:1] r_q, r_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b0;
    KEY_INDEX = 4'd0;
    unique case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          l_d     = LEFT0;
          r_d     = RIGHT0;
          mode_d  = DECRYPT;
          cnt_d   = 4'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        BUSY      = 1'b1;
        KEY_INDEX = mode_q ? (LAST - cnt_q) : cnt_q;
        l_d       = r_q;
        r_d       = l_q ^ F_OUT;
        if (cnt_q == LAST) begin
          // wrap so cnt never leaves 0..ROUNDS-1
          cnt_d   = 4'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        BUSY      = 1'b1;
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign F_R     = r_q;
  assign LEFT16  = l_q;
  assign RIGHT16 = r_q;

endmodule

// File: tb/tb_feistel_round_ctrl.sv
// Directed bench for feistel_round_ctrl: 16-round and 1-round instances.
// Table vectors plus hand sequences for inverse, backpressure and mid-block reset.
module tb_feistel_round_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  int          errors = 0;
  int          checks = 0;

  logic        a_iv, a_ir, a_dec, a_ov, a_ordy, a_busy;
  logic [31:0] a_l0, a_r0, a_fr, a_fo, a_l16, a_r16, fa_c;
  logic [3:0]  a_key;
  logic        f_sel;

  logic        b_iv, b_ir, b_dec, b_ov, b_ordy, b_busy;
  logic [31:0] b_l0, b_r0, b_fr, b_fo, b_l16, b_r16, fb_c;
  logic [3:0]  b_key;

  always #5 clk = ~clk;

  function automatic logic [31:0] stub(logic [31:0] r, logic [3:0] k);
    logic [31:0] x;
    x = r ^ {28'h0, k};
    return (x << k) | (x >> (6'd32 - {2'b00, k}));
  endfunction

  assign a_fo = f_sel ? stub(a_fr, a_key) : fa_c;
  assign b_fo = fb_c;

  feistel_round_ctrl #(.ROUNDS(16)) u_a (
    .CLK(clk), .RESET(rst), .IN_VALID(a_iv), .IN_READY(a_ir),
    .DECRYPT(a_dec), .LEFT0(a_l0), .RIGHT0(a_r0), .KEY_INDEX(a_key),
    .F_R(a_fr), .F_OUT(a_fo), .LEFT16(a_l16), .RIGHT16(a_r16),
    .OUT_VALID(a_ov), .OUT_READY(a_ordy), .BUSY(a_busy)
  );

  feistel_round_ctrl #(.ROUNDS(1)) u_b (
    .CLK(clk), .RESET(rst), .IN_VALID(b_iv), .IN_READY(b_ir),
    .DECRYPT(b_dec), .LEFT0(b_l0), .RIGHT0(b_r0), .KEY_INDEX(b_key),
    .F_R(b_fr), .F_OUT(b_fo), .LEFT16(b_l16), .RIGHT16(b_r16),
    .OUT_VALID(b_ov), .OUT_READY(b_ordy), .BUSY(b_busy)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_a(input logic [31:0] l0, r0, input logic dec, tog,
                       input int hold, output int lat,
                       output logic [31:0] gl, gr, fr0, fr1,
                       output logic [63:0] keys);
    int nk;
    nk = 0; keys = '0; fr0 = '0; fr1 = '0;
    @(negedge clk);
    chk("a_in_ready", {127'b0, a_ir}, 128'd1);
    a_iv = 1'b1; a_l0 = l0; a_r0 = r0; a_dec = dec;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    a_iv = 1'b0;
    while (lat < 40) begin
      if (a_ov) break;
      if (nk == 0) fr0 = a_fr;
      if (nk == 1) fr1 = a_fr;
      if (nk < 16) keys[nk*4 +: 4] = a_key;
      nk++;
      if (tog) begin
        a_dec = ~a_dec; a_iv = 1'b1; a_l0 = ~a_l0; a_r0 = a_r0 + 1;
      end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (!a_ov) chk("a_timeout", 128'd0, 128'd1);
    gl = a_l16; gr = a_r16;
    for (int i = 0; i < hold; i++) begin
      a_iv = 1'b1; a_l0 = 32'hBAD0BAD0;
      @(posedge clk);
      @(negedge clk);
      chk("a_hold", {a_ov, a_ir, a_busy, a_l16, a_r16},
          {3'b101, gl, gr});
    end
    a_iv = 1'b1; a_ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_ordy = 1'b0; a_iv = 1'b0;
    chk("a_release", {a_ov, a_ir, a_busy, a_l16, a_r16},
        {3'b010, gl, gr});
  endtask

  task automatic run_b(input logic [31:0] l0, r0, input logic dec,
                       output int lat, output logic [31:0] gl, gr);
    @(negedge clk);
    b_iv = 1'b1; b_l0 = l0; b_r0 = r0; b_dec = dec;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    b_iv = 1'b0;
    chk("b_key", {124'b0, b_key}, 128'd0);
    while (lat < 10) begin
      if (b_ov) break;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    gl = b_l16; gr = b_r16;
    b_ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_ordy = 1'b0;
    chk("b_release", {126'b0, b_ov, b_ir}, 128'd1);
  endtask

  typedef struct {
    logic [31:0] l0, r0;
    logic        dec, tog, one;
    logic [31:0] c, el, er;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    logic [31:0] gl, gr, fr0, fr1, gl2, gr2;
    logic [63:0] keys;

    vecs[0] = '{32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0,
                32'h00000000, 32'h01234567, 32'h89ABCDEF};
    vecs[1] = '{32'hDEADBEEF, 32'h0BADF00D, 1'b1, 1'b1, 1'b0,
                32'hFFFFFFFF, 32'hDEADBEEF, 32'h0BADF00D};
    vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b0,
                32'hA5A5A5A5, 32'h12345678, 32'h9ABCDEF0};
    vecs[3] = '{32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0, 1'b1,
                32'hFFFFFFFF, 32'h89ABCDEF, 32'hFEDCBA98};
    vecs[4] = '{32'hA5A50F0F, 32'h00FF00FF, 1'b1, 1'b0, 1'b1,
                32'h0F0F0F0F, 32'h00FF00FF, 32'hAAAA0000};

    rst = 1'b1; f_sel = 1'b0; fa_c = '0; fb_c = '0;
    a_iv = 0; a_dec = 0; a_l0 = 0; a_r0 = 0; a_ordy = 0;
    b_iv = 0; b_dec = 0; b_l0 = 0; b_r0 = 0; b_ordy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {a_ov, a_ir, a_busy, a_key}, {121'b0, 7'b0100000});
    chk("rst_data", {a_l16, a_r16, a_fr}, 128'd0);
    chk("rst_b", {b_ov, b_ir, b_busy, b_l16}, {93'b0, 3'b010, 32'd0});
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].one) begin
        fb_c = vecs[i].c;
        run_b(vecs[i].l0, vecs[i].r0, vecs[i].dec, lat, gl, gr);
        chk("b_latency", 128'(lat), 128'd1);
        chk("b_result", {gl, gr}, {vecs[i].el, vecs[i].er});
      end else begin
        fa_c = vecs[i].c;
        run_a(vecs[i].l0, vecs[i].r0, vecs[i].dec, vecs[i].tog,
              (i == 0) ? 10 : 0, lat, gl, gr, fr0, fr1, keys);
        chk("a_latency", 128'(lat), 128'd16);
        chk("a_result", {gl, gr}, {vecs[i].el, vecs[i].er});
        chk("a_keyseq", 128'(keys), vecs[i].dec ?
            128'h0123456789ABCDEF : 128'hFEDCBA9876543210);
        chk("a_fr", {fr0, fr1}, {vecs[i].r0, vecs[i].l0 ^ vecs[i].c});
      end
    end

    f_sel = 1'b1;
    run_a(32'h13579BDF, 32'h2468ACE0, 1'b0, 1'b0, 0,
          lat, gl, gr, fr0, fr1, keys);
    chk("inv_enc_keys", 128'(keys), 128'hFEDCBA9876543210);
    run_a(gr, gl, 1'b1, 1'b0, 0, lat, gl2, gr2, fr0, fr1, keys);
    chk("inv_dec_keys", 128'(keys), 128'h0123456789ABCDEF);
    chk("inverse", {gl2, gr2}, {32'h2468ACE0, 32'h13579BDF});
    f_sel = 1'b0;

    fa_c = 32'h5A5A5A5A;
    @(negedge clk);
    a_iv = 1'b1; a_l0 = 32'hCAFEF00D; a_r0 = 32'h12345678; a_dec = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_iv = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_cnt7", {124'b0, a_key}, 128'd7);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ctl", {a_ov, a_ir, a_busy, a_key}, {121'b0, 7'b0100000});
    chk("mid_rst_data", {a_l16, a_r16, a_fr}, 128'd0);
    repeat (20) @(negedge clk);
    chk("mid_no_result", {126'b0, a_ov, a_ir}, 128'd1);
    fa_c = 32'h0;
    run_a(32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0, 0,
          lat, gl, gr, fr0, fr1, keys);
    chk("post_rst_latency", 128'(lat), 128'd16);
    chk("post_rst_result", {gl, gr}, {32'h01234567, 32'h89ABCDEF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/feistel_round_ctrl.md
FEISTEL_ROUND_CTRL -- requirements
Module: feistel_round_ctrl

Interface
REQ-001 Parameter: ROUNDS, 16, number of Feistel rounds per block; legal range 1..16.
REQ-002 Port: CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: RESET  input  1  reset, synchronous and active-high.
REQ-004 Port: IN_VALID  input  1  upstream presents LEFT0/RIGHT0/DECRYPT.
REQ-005 Port: IN_READY  output  1  block can accept a new block.
REQ-006 Port: DECRYPT  input  1  0 = ascending key order, 1 = descending key order.
REQ-007 Port: LEFT0  input  [32:1]  left half after initial permutation.
REQ-008 Port: RIGHT0  input  [32:1]  right half after initial permutation.
REQ-009 Port: KEY_INDEX  output  4  subkey number for the external key schedule.
REQ-010 Port: F_R  output  [32:1]  current right half, driven to the external F function.
REQ-011 Port: F_OUT  input  [32:1]  F(F_R, subkey[KEY_INDEX]), combinational, same cycle.
REQ-012 Port: LEFT16  output  [32:1]  final left half, unswapped; the downstream swap stage consumes it.
REQ-013 Port: RIGHT16  output  [32:1]  final right half, unswapped.
REQ-014 Port: OUT_VALID  output  1  LEFT16/RIGHT16 hold a completed result.
REQ-015 Port: OUT_READY  input  1  downstream accepts the result.
REQ-016 Port: BUSY  output  1  high in ROUND and HOLD.

Function
REQ-017 FSM states SHALL be IDLE, ROUND and HOLD.
REQ-018 IN_READY SHALL be 1 only in IDLE.
REQ-019 IDLE, IN_VALID=1: L<=LEFT0, R<=RIGHT0, mode<=DECRYPT, cnt<=0, next state ROUND.
REQ-020 DECRYPT SHALL be sampled only at accept; later changes during the block are ignored.
REQ-021 ROUND, every cycle: L<=R, R<=L xor F_OUT, cnt<=cnt+1.
REQ-022 ROUND, when cnt=ROUNDS-1: perform the final update and go to HOLD.
REQ-023 ROUND: KEY_INDEX = cnt when mode=0, ROUNDS-1-cnt when mode=1.
REQ-024 IDLE and HOLD: KEY_INDEX SHALL be 0.
REQ-025 F_R SHALL equal register R in every state.
REQ-026 Latency: accept edge at cycle 0; OUT_VALID SHALL rise after exactly ROUNDS further edges.
REQ-027 HOLD: OUT_VALID=1, LEFT16=L, RIGHT16=R; outputs stay stable until OUT_READY=1 (backpressure of any length).
REQ-028 HOLD with OUT_READY=1: go to IDLE next edge; no new accept on that same edge.
REQ-029 OUT_VALID=0 in IDLE and ROUND; LEFT16/RIGHT16 SHALL equal the L/R registers in all states.
REQ-030 OUT_READY SHALL be ignored outside HOLD.
REQ-031 IN_VALID SHALL be ignored outside IDLE, with no effect on L, R or cnt.
REQ-032 cnt SHALL be 4 bits wide and never exceed ROUNDS-1; KEY_INDEX SHALL never exceed 15.
REQ-033 The block SHALL perform no bit permutation or swap of its own.

Reset
REQ-034 With RESET=1 at an edge: state=IDLE, L=0, R=0, cnt=0, mode=0.
REQ-035 Outputs after such an edge: OUT_VALID=0, IN_READY=1, BUSY=0, KEY_INDEX=0, LEFT16=RIGHT16=F_R=0.
REQ-036 RESET SHALL override all other inputs in any state, including mid-ROUND and HOLD; no partial result is output afterwards.

Verification
REQ-037 Transparent F: F_OUT=0, LEFT0=32'h01234567, RIGHT0=32'h89ABCDEF, ROUNDS=16 -> OUT_VALID high 16 edges after accept; LEFT16=32'h01234567, RIGHT16=32'h89ABCDEF.
REQ-038 Key order: DECRYPT=0 -> KEY_INDEX 0,1,...,15 on the 16 ROUND cycles; DECRYPT=1 -> 15,14,...,0; DECRYPT toggled mid-block -> sequence unchanged.
REQ-039 Inverse check (stub F_OUT = F_R xor {28'h0,KEY_INDEX} rotated left by KEY_INDEX):
  - Step 1: encrypt (L0,R0).
  - Step 2: feed (RIGHT16,LEFT16) with DECRYPT=1.
  - Required: LEFT16=R0 and RIGHT16=L0.
REQ-040 Backpressure: hold OUT_READY=0 for 10 cycles in HOLD -> outputs stable and IN_READY=0 throughout; OUT_READY=1 for one cycle -> IDLE with IN_READY=1 on the next edge.
REQ-041 Reset mid-operation: RESET=1 at ROUND cnt=7 -> next cycle IDLE, all outputs at their reset values; a fresh block then completes in 16 cycles with the correct result.
REQ-042 ROUNDS=1 instance: F_OUT=32'hFFFFFFFF -> LEFT16=RIGHT0, RIGHT16=~LEFT0, OUT_VALID one edge after accept.
